// File: rtl/kronos_types.sv
// Shared Kronos type definitions: CSR operation encoding and datapath widths
// used by the CSR arbiter and the CSR file.
package kronos_types;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CSR_DATA_W = 32;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/kronos_csr_arbiter.sv
// Two-requester (core / debug) arbiter in front of the CSR file: grants one
// request at a time, forwards it, and returns the old value or a timeout error.
module kronos_csr_arbiter
  import kronos_types::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned DBG_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rstz,
  input  logic                  req0_vld,
  input  logic [CSR_ADDR_W-1:0] req0_addr,
  input  logic [1:0]            req0_op,
  input  logic [CSR_DATA_W-1:0] req0_wdata,
  output logic                  req0_rdy,
  output logic [CSR_DATA_W-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_vld,
  input  logic [CSR_ADDR_W-1:0] req1_addr,
  input  logic [1:0]            req1_op,
  input  logic [CSR_DATA_W-1:0] req1_wdata,
  output logic                  req1_rdy,
  output logic [CSR_DATA_W-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  csr_vld,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [1:0]            csr_op,
  output logic [CSR_DATA_W-1:0] csr_wdata,
  input  logic                  csr_rdy,
  input  logic [CSR_DATA_W-1:0] csr_rdata,
  output logic                  busy,
  output logic                  gnt_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Last ISSUE cycle value of the counter; success still wins on that cycle.
  localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [7:0]              cnt_r;
  logic                    gnt_id_r;
  logic [CSR_ADDR_W-1:0]   addr_r;
  csr_op_e                 op_r;
  logic [CSR_DATA_W-1:0]   wdata_r;
  logic                    csr_vld_r;
  logic                    busy_r;
  logic [1:0]              rdy_r;
  logic                    err0_r;
  logic                    err1_r;
  logic [CSR_DATA_W-1:0]   rdata0_r;
  logic [CSR_DATA_W-1:0]   rdata1_r;

  logic                    any_vld_s;
  logic                    gnt_s;
  logic                    done_ok_s;
  logic                    done_to_s;
  logic                    csr_vld_nxt_s;
  logic                    busy_nxt_s;
  logic [1:0]              rdy_nxt_s;
  logic [CSR_DATA_W-1:0]   resp_data_s;
  logic                    resp_err_s;

  // Arbitration: round-robin against the last owner, or fixed debug priority.
  always_comb begin
    any_vld_s = req0_vld | req1_vld;
    gnt_s     = 1'b0;
    if (req0_vld && req1_vld) begin
      if (DBG_PRIO != 32'd0) begin
        gnt_s = 1'b1;
      end else begin
        gnt_s = ~gnt_id_r;
      end
    end else if (req1_vld) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Completion conditions evaluated during ISSUE.
  always_comb begin
    done_ok_s = (state_r == ST_ISSUE) && csr_rdy;
    done_to_s = (state_r == ST_ISSUE) && !csr_rdy && (cnt_r == TO_LAST_C);
  end

  // State register.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_vld_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (done_ok_s || done_to_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every port comes straight off a flop.
  always_comb begin
    csr_vld_nxt_s = (state_nxt_s == ST_ISSUE);
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    if (state_nxt_s == ST_RESP) begin
      rdy_nxt_s = gnt_id_r ? 2'b10 : 2'b01;
    end else begin
      rdy_nxt_s = 2'b00;
    end
    if (done_ok_s) begin
      resp_data_s = csr_rdata;
      resp_err_s  = 1'b0;
    end else begin
      resp_data_s = {CSR_DATA_W{1'b0}};
      resp_err_s  = 1'b1;
    end
  end

  // Grant capture and ISSUE-cycle counter.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      gnt_id_r <= 1'b1;
      addr_r   <= {CSR_ADDR_W{1'b0}};
      op_r     <= CSR_OP_NONE;
      wdata_r  <= {CSR_DATA_W{1'b0}};
      cnt_r    <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) && any_vld_s) begin
        gnt_id_r <= gnt_s;
        addr_r   <= gnt_s ? req1_addr : req0_addr;
        op_r     <= csr_op_e'(gnt_s ? req1_op : req0_op);
        wdata_r  <= gnt_s ? req1_wdata : req0_wdata;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
    end
  end

  // Registered handshake outputs; response data/err hold between pulses.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      csr_vld_r <= 1'b0;
      busy_r    <= 1'b0;
      rdy_r     <= 2'b00;
      err0_r    <= 1'b0;
      err1_r    <= 1'b0;
      rdata0_r  <= {CSR_DATA_W{1'b0}};
      rdata1_r  <= {CSR_DATA_W{1'b0}};
    end else begin
      csr_vld_r <= csr_vld_nxt_s;
      busy_r    <= busy_nxt_s;
      rdy_r     <= rdy_nxt_s;
      if (rdy_nxt_s[0]) begin
        rdata0_r <= resp_data_s;
        err0_r   <= resp_err_s;
      end
      if (rdy_nxt_s[1]) begin
        rdata1_r <= resp_data_s;
        err1_r   <= resp_err_s;
      end
    end
  end

  assign csr_vld    = csr_vld_r;
  assign csr_addr   = addr_r;
  assign csr_op     = op_r;
  assign csr_wdata  = wdata_r;
  assign busy       = busy_r;
  assign gnt_id     = gnt_id_r;
  assign req0_rdy   = rdy_r[0];
  assign req1_rdy   = rdy_r[1];
  assign req0_rdata = rdata0_r;
  assign req1_rdata = rdata1_r;
  assign req0_err   = err0_r;
  assign req1_err   = err1_r;

endmodule

// File: tb/tb_kronos_csr_arbiter.sv
// Directed bench for kronos_csr_arbiter: a round-robin instance (a_*) and a
// debug-priority instance (b_*) share all inputs and run in lockstep.
module tb_kronos_csr_arbiter;

  logic        clk = 1'b0;
  logic        rstz;
  logic        req0_vld, req1_vld;
  logic [11:0] req0_addr, req1_addr;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_wdata, req1_wdata;
  logic        csr_rdy;
  logic [31:0] csr_rdata;

  logic        a_req0_rdy, a_req1_rdy, a_req0_err, a_req1_err, a_csr_vld, a_busy, a_gnt_id;
  logic [31:0] a_req0_rdata, a_req1_rdata, a_csr_wdata;
  logic [11:0] a_csr_addr;
  logic [1:0]  a_csr_op;
  logic        b_req0_rdy, b_req1_rdy, b_req0_err, b_req1_err, b_csr_vld, b_busy, b_gnt_id;
  logic [31:0] b_req0_rdata, b_req1_rdata, b_csr_wdata;
  logic [11:0] b_csr_addr;
  logic [1:0]  b_csr_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  kronos_csr_arbiter #(.TIMEOUT(16), .DBG_PRIO(0)) u_dut_rr (
    .clk(clk), .rstz(rstz),
    .req0_vld(req0_vld), .req0_addr(req0_addr), .req0_op(req0_op), .req0_wdata(req0_wdata),
    .req0_rdy(a_req0_rdy), .req0_rdata(a_req0_rdata), .req0_err(a_req0_err),
    .req1_vld(req1_vld), .req1_addr(req1_addr), .req1_op(req1_op), .req1_wdata(req1_wdata),
    .req1_rdy(a_req1_rdy), .req1_rdata(a_req1_rdata), .req1_err(a_req1_err),
    .csr_vld(a_csr_vld), .csr_addr(a_csr_addr), .csr_op(a_csr_op), .csr_wdata(a_csr_wdata),
    .csr_rdy(csr_rdy), .csr_rdata(csr_rdata), .busy(a_busy), .gnt_id(a_gnt_id)
  );

  kronos_csr_arbiter #(.TIMEOUT(16), .DBG_PRIO(1)) u_dut_dbg (
    .clk(clk), .rstz(rstz),
    .req0_vld(req0_vld), .req0_addr(req0_addr), .req0_op(req0_op), .req0_wdata(req0_wdata),
    .req0_rdy(b_req0_rdy), .req0_rdata(b_req0_rdata), .req0_err(b_req0_err),
    .req1_vld(req1_vld), .req1_addr(req1_addr), .req1_op(req1_op), .req1_wdata(req1_wdata),
    .req1_rdy(b_req1_rdy), .req1_rdata(b_req1_rdata), .req1_err(b_req1_err),
    .csr_vld(b_csr_vld), .csr_addr(b_csr_addr), .csr_op(b_csr_op), .csr_wdata(b_csr_wdata),
    .csr_rdy(csr_rdy), .csr_rdata(csr_rdata), .busy(b_busy), .gnt_id(b_gnt_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_vld = 1'b0; req0_addr = 12'h000; req0_op = 2'b00; req0_wdata = 32'h0;
    req1_vld = 1'b0; req1_addr = 12'h000; req1_op = 2'b00; req1_wdata = 32'h0;
    csr_rdy  = 1'b0; csr_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstz = 1'b0;
    tick();
    tick();
    rstz = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rstz = 1'b0;
    #1;
    checks++; if (a_csr_vld !== 1'b0) begin errors++; $display("FAIL reset_csr_vld got=%b exp=0", a_csr_vld); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_gnt_id !== 1'b1 || b_gnt_id !== 1'b1) begin errors++; $display("FAIL reset_gnt_id got=%b/%b exp=1/1", a_gnt_id, b_gnt_id); end
    checks++; if ({a_req1_rdy, a_req0_rdy, a_req1_err, a_req0_err} !== 4'b0000) begin errors++; $display("FAIL reset_rdy_err got=%b exp=0000", {a_req1_rdy, a_req0_rdy, a_req1_err, a_req0_err}); end
    checks++; if (a_req0_rdata !== 32'h0 || a_req1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", a_req0_rdata, a_req1_rdata); end
    rstz = 1'b1;
  endtask

  task automatic test_single();
    req0_vld = 1'b1; req0_addr = 12'h340; req0_op = 2'b01; req0_wdata = 32'h0000_00A5;
    tick();
    checks++; if (a_csr_vld !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL single_issue vld/busy got=%b/%b exp=1/1", a_csr_vld, a_busy); end
    checks++; if (a_csr_addr !== 12'h340 || a_csr_op !== 2'b01 || a_csr_wdata !== 32'h0000_00A5) begin errors++; $display("FAIL single_fields got=%h/%b/%h exp=340/01/a5", a_csr_addr, a_csr_op, a_csr_wdata); end
    checks++; if (a_gnt_id !== 1'b0) begin errors++; $display("FAIL single_gnt got=%b exp=0", a_gnt_id); end
    tick();
    tick();
    checks++; if (a_csr_vld !== 1'b1 || a_csr_wdata !== 32'h0000_00A5 || a_req0_rdy !== 1'b0) begin errors++; $display("FAIL single_hold vld/wdata/rdy got=%b/%h/%b exp=1/a5/0", a_csr_vld, a_csr_wdata, a_req0_rdy); end
    csr_rdy = 1'b1; csr_rdata = 32'h0000_0011;
    tick();
    checks++; if (a_req0_rdy !== 1'b1 || a_req1_rdy !== 1'b0) begin errors++; $display("FAIL single_rdy got=%b%b exp=01", a_req1_rdy, a_req0_rdy); end
    checks++; if (a_req0_rdata !== 32'h0000_0011 || a_req0_err !== 1'b0) begin errors++; $display("FAIL single_rdata got=%h err=%b exp=11 err=0", a_req0_rdata, a_req0_err); end
    checks++; if (a_csr_vld !== 1'b0) begin errors++; $display("FAIL single_vld_drop got=%b exp=0", a_csr_vld); end
    req0_vld = 1'b0; csr_rdy = 1'b0; csr_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (a_req0_rdy !== 1'b0 || a_req0_rdata !== 32'h0000_0011 || a_busy !== 1'b0) begin errors++; $display("FAIL single_after rdy/rdata/busy got=%b/%h/%b exp=0/11/0", a_req0_rdy, a_req0_rdata, a_busy); end
  endtask

  task automatic test_contention();
    logic exp_id;
    apply_reset();
    req0_vld = 1'b1; req0_addr = 12'h300; req0_op = 2'b10; req0_wdata = 32'h0000_000F;
    req1_vld = 1'b1; req1_addr = 12'h7B0; req1_op = 2'b11; req1_wdata = 32'h0000_00F0;
    for (int r = 0; r < 3; r++) begin
      exp_id = (r == 1);
      tick();
      checks++; if (a_gnt_id !== exp_id) begin errors++; $display("FAIL rr_gnt round=%0d got=%b exp=%b", r, a_gnt_id, exp_id); end
      checks++; if (a_csr_addr !== (exp_id ? 12'h7B0 : 12'h300)) begin errors++; $display("FAIL rr_addr round=%0d got=%h", r, a_csr_addr); end
      csr_rdy = 1'b1; csr_rdata = 32'h0000_1000 + 32'(r);
      tick();
      csr_rdy = 1'b0;
      checks++; if ({a_req1_rdy, a_req0_rdy} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rdy round=%0d got=%b%b", r, a_req1_rdy, a_req0_rdy); end
      checks++; if ((exp_id ? a_req1_rdata : a_req0_rdata) !== 32'h0000_1000 + 32'(r)) begin errors++; $display("FAIL rr_rdata round=%0d got=%h/%h", r, a_req0_rdata, a_req1_rdata); end
      tick();
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rr_idle round=%0d busy got=%b exp=0", r, a_busy); end
    end
    clear_inputs();
  endtask

  task automatic test_dbg_prio();
    apply_reset();
    req0_vld = 1'b1; req0_addr = 12'h300; req0_op = 2'b01; req0_wdata = 32'h0000_0001;
    req1_vld = 1'b1; req1_addr = 12'h7B1; req1_op = 2'b01; req1_wdata = 32'h0000_0002;
    for (int r = 0; r < 3; r++) begin
      tick();
      checks++; if (b_gnt_id !== 1'b1 || b_csr_addr !== 12'h7B1) begin errors++; $display("FAIL dbg_gnt round=%0d got=%b addr=%h exp=1 addr=7b1", r, b_gnt_id, b_csr_addr); end
      csr_rdy = 1'b1; csr_rdata = 32'h0000_2000 + 32'(r);
      tick();
      csr_rdy = 1'b0;
      checks++; if ({b_req1_rdy, b_req0_rdy} !== 2'b10 || b_req1_rdata !== 32'h0000_2000 + 32'(r)) begin errors++; $display("FAIL dbg_rdy round=%0d got=%b%b rdata=%h", r, b_req1_rdy, b_req0_rdy, b_req1_rdata); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int  vld_cycles = 0;
    bit  done = 1'b0;
    req1_vld = 1'b1; req1_addr = 12'h7C0; req1_op = 2'b01; req1_wdata = 32'h0000_0055;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (a_csr_vld === 1'b1) vld_cycles++;
      if (a_req1_rdy === 1'b1) done = 1'b1;
    end
    req1_vld = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL timeout_wait no req1_rdy within 40 cycles"); end
    checks++; if (vld_cycles != 16) begin errors++; $display("FAIL timeout_vld_cycles got=%0d exp=16", vld_cycles); end
    checks++; if (a_req1_err !== 1'b1 || a_req1_rdata !== 32'h0) begin errors++; $display("FAIL timeout_resp err=%b rdata=%h exp err=1 rdata=0", a_req1_err, a_req1_rdata); end
    checks++; if (b_req1_err !== 1'b1 || b_req1_rdata !== 32'h0) begin errors++; $display("FAIL timeout_resp_dbg err=%b rdata=%h exp err=1 rdata=0", b_req1_err, b_req1_rdata); end
    tick();
    checks++; if (a_req1_rdy !== 1'b0 || a_req1_err !== 1'b1) begin errors++; $display("FAIL timeout_hold rdy=%b err=%b exp 0/1", a_req1_rdy, a_req1_err); end
  endtask

  task automatic test_late_rdy();
    bit early = 1'b0;
    req1_vld = 1'b1; req1_addr = 12'h7C1; req1_op = 2'b10; req1_wdata = 32'h0000_0077;
    tick();
    for (int i = 0; i < 15; i++) begin
      if (a_csr_vld !== 1'b1 || a_req1_rdy !== 1'b0) early = 1'b1;
      tick();
    end
    checks++; if (early || a_csr_vld !== 1'b1) begin errors++; $display("FAIL late_hold csr_vld=%b early_end=%b exp 1/0", a_csr_vld, early); end
    csr_rdy = 1'b1; csr_rdata = 32'hCAFE_0016;
    tick();
    checks++; if (a_req1_rdy !== 1'b1 || a_req1_err !== 1'b0 || a_req1_rdata !== 32'hCAFE_0016) begin errors++; $display("FAIL late_rdy rdy=%b err=%b rdata=%h exp 1/0/cafe0016", a_req1_rdy, a_req1_err, a_req1_rdata); end
    req1_vld = 1'b0; csr_rdy = 1'b0;
    tick();
    csr_rdy = 1'b1; csr_rdata = 32'h1234_5678;
    tick();
    tick();
    csr_rdy = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_req1_rdy !== 1'b0 || a_req1_rdata !== 32'hCAFE_0016) begin errors++; $display("FAIL stray_rdy busy=%b rdy=%b rdata=%h exp 0/0/cafe0016", a_busy, a_req1_rdy, a_req1_rdata); end
  endtask

  task automatic test_reset_mid();
    bit pulse = 1'b0;
    req0_vld = 1'b1; req0_addr = 12'h341; req0_op = 2'b01; req0_wdata = 32'h0000_0099;
    tick();
    tick();
    checks++; if (a_csr_vld !== 1'b1) begin errors++; $display("FAIL midrst_pre csr_vld got=%b exp=1", a_csr_vld); end
    rstz = 1'b0;
    #1;
    checks++; if (a_csr_vld !== 1'b0 || a_busy !== 1'b0 || a_gnt_id !== 1'b1) begin errors++; $display("FAIL midrst_now vld=%b busy=%b gnt=%b exp 0/0/1", a_csr_vld, a_busy, a_gnt_id); end
    req0_vld = 1'b0;
    tick();
    rstz = 1'b1;
    csr_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_req0_rdy !== 1'b0 || a_req1_rdy !== 1'b0) pulse = 1'b1;
    end
    csr_rdy = 1'b0;
    checks++; if (pulse) begin errors++; $display("FAIL midrst_pulse rdy seen after aborted transaction"); end
    req0_vld = 1'b1; req1_vld = 1'b1; req1_addr = 12'h7B0;
    tick();
    checks++; if (a_gnt_id !== 1'b0 || a_csr_addr !== 12'h341) begin errors++; $display("FAIL midrst_first_gnt gnt=%b addr=%h exp 0/341", a_gnt_id, a_csr_addr); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rstz = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_dbg_prio();
    test_timeout();
    test_late_rdy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
